// File: rtl/snake_multi_timer_if.sv
// Avalon-MM slave bus bundle for snake_multi_timer: word-addressed register
// access plus the combined interrupt line.
interface snake_multi_timer_if #(
    parameter int unsigned NUM_CH = 2
) ();
    localparam int unsigned ADDR_W = 3 + $clog2(NUM_CH);

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/snake_multi_timer.sv
// Multi-channel interval timer: NUM_CH down-counters with period, snapshot,
// one-shot/continuous mode and a combined level IRQ. Optional per-channel
// prescaler is built only when SNAKE_TIMER_PRESCALE_EN is defined.
module snake_multi_timer #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned CNT_W        = 32,
    parameter logic [31:0] RESET_PERIOD = 32'd119999,
    parameter int unsigned PRE_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    snake_multi_timer_if.slave   bus
);
    localparam int unsigned CH_BITS  = $clog2(NUM_CH);
    localparam int unsigned ADDR_W   = 3 + CH_BITS;
    localparam int unsigned CH_IDX_W = (CH_BITS > 0) ? CH_BITS : 1;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PER_LO   = 3'd2;
    localparam logic [2:0] REG_PER_HI   = 3'd3;
    localparam logic [2:0] REG_SNAP_LO  = 3'd4;
    localparam logic [2:0] REG_SNAP_HI  = 3'd5;
    localparam logic [2:0] REG_PRESCALE = 3'd6;

    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);

    logic [2:0]          reg_sel;
    logic [CH_IDX_W-1:0] ch_sel;
    logic                ch_valid;
    logic                wr_en;

    logic [CNT_W-1:0]    ch_period [NUM_CH];
    logic [CNT_W-1:0]    ch_snap   [NUM_CH];
    logic [PRE_W-1:0]    ch_pre    [NUM_CH];
    logic [NUM_CH-1:0]   ch_run;
    logic [NUM_CH-1:0]   ch_to;
    logic [NUM_CH-1:0]   ch_ito;
    logic [NUM_CH-1:0]   ch_cont;
    logic [NUM_CH-1:0]   ch_irq;

    logic [31:0]         rd_q, rd_d;
    logic                irq_q, irq_d;

    assign reg_sel = bus.address[2:0];

    if (CH_BITS > 0) begin : g_chsel
        assign ch_sel = bus.address[ADDR_W-1:3];
    end else begin : g_chsel_single
        assign ch_sel = 1'b0;
    end

    // Channel numbers at or above NUM_CH are holes in the map.
    assign ch_valid = (32'(ch_sel) < NUM_CH);
    assign wr_en    = bus.chipselect && !bus.write_n && ch_valid;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [CH_IDX_W-1:0] CH_ID = CH_IDX_W'(g);

        logic [CNT_W-1:0] cnt_q, cnt_d, cnt_step;
        logic [CNT_W-1:0] period_q, period_d;
        logic [CNT_W-1:0] snap_q, snap_d;
        logic [63:0]      period_w;
        logic             run_q, run_d;
        logic             to_q, to_d;
        logic             ito_q, ito_d;
        logic             cont_q, cont_d;
        logic             force_q, force_d;
        logic             zero_q, zero_d;
        logic             sel, wr_status, wr_ctrl, wr_period, wr_snap;
        logic             start, stop, tick, zero_stop, to_evt;

        assign sel       = wr_en && (ch_sel == CH_ID);
        assign wr_status = sel && (reg_sel == REG_STATUS);
        assign wr_ctrl   = sel && (reg_sel == REG_CONTROL);
        assign wr_period = sel && ((reg_sel == REG_PER_LO) || (reg_sel == REG_PER_HI));
        assign wr_snap   = sel && ((reg_sel == REG_SNAP_LO) || (reg_sel == REG_SNAP_HI));
        assign start     = wr_ctrl && bus.writedata[2];
        assign stop      = wr_ctrl && bus.writedata[3];

`ifdef SNAKE_TIMER_PRESCALE_EN
        logic [PRE_W-1:0] pre_q, pre_d;
        logic [PRE_W-1:0] pcnt_q, pcnt_d;
        logic             wr_pre;

        assign wr_pre = sel && (reg_sel == REG_PRESCALE);
        assign tick   = (pcnt_q == pre_q);

        // Prescaler restarts so the first tick after START/reload is a full interval.
        always_comb begin
            pre_d  = pre_q;
            pcnt_d = pcnt_q;
            if (wr_pre) begin
                pre_d = PRE_W'(bus.writedata);
            end
            if (start || wr_pre || force_q) begin
                pcnt_d = '0;
            end else if (run_q) begin
                pcnt_d = tick ? '0 : pcnt_q + PRE_W'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pre_q  <= '0;
                pcnt_q <= '0;
            end else begin
                pre_q  <= pre_d;
                pcnt_q <= pcnt_d;
            end
        end

        assign ch_pre[g] = pre_q;
`else
        assign tick      = 1'b1;
        assign ch_pre[g] = '0;
`endif

        assign period_w = 64'(period_q);
        assign cnt_step = (cnt_q == '0) ? period_q : cnt_q - CNT_W'(1);

        always_comb begin
            period_d  = period_q;
            cnt_d     = cnt_q;
            run_d     = run_q;
            to_d      = to_q;
            ito_d     = ito_q;
            cont_d    = cont_q;
            snap_d    = snap_q;
            force_d   = wr_period;
            zero_d    = (cnt_q == '0);
            zero_stop = 1'b0;
            to_evt    = (cnt_q == '0) && !zero_q;

            if (sel && (reg_sel == REG_PER_LO)) begin
                period_d = CNT_W'({period_w[63:32], bus.writedata});
            end
            if (sel && (reg_sel == REG_PER_HI)) begin
                period_d = CNT_W'({bus.writedata, period_w[31:0]});
            end

            if (force_q) begin
                cnt_d = period_q;
            end else if (run_q && tick) begin
                cnt_d     = cnt_step;
                zero_stop = !cont_q && (cnt_step == '0);
            end

            // START > STOP/period write/force_reload > one-shot expiry.
            if (start) begin
                run_d = 1'b1;
            end else if (stop || wr_period || force_q) begin
                run_d = 1'b0;
            end else if (zero_stop) begin
                run_d = 1'b0;
            end

            // A timeout landing on a STATUS write must not be lost.
            if (to_evt) begin
                to_d = 1'b1;
            end else if (wr_status) begin
                to_d = 1'b0;
            end

            if (wr_ctrl) begin
                ito_d  = bus.writedata[0];
                cont_d = bus.writedata[1];
            end

            if (wr_snap) begin
                snap_d = cnt_q;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q    <= RST_CNT;
                period_q <= RST_CNT;
                snap_q   <= '0;
                run_q    <= 1'b0;
                to_q     <= 1'b0;
                ito_q    <= 1'b0;
                cont_q   <= 1'b0;
                force_q  <= 1'b0;
                zero_q   <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                period_q <= period_d;
                snap_q   <= snap_d;
                run_q    <= run_d;
                to_q     <= to_d;
                ito_q    <= ito_d;
                cont_q   <= cont_d;
                force_q  <= force_d;
                zero_q   <= zero_d;
            end
        end

        assign ch_period[g] = period_q;
        assign ch_snap[g]   = snap_q;
        assign ch_run[g]    = run_q;
        assign ch_to[g]     = to_q;
        assign ch_ito[g]    = ito_q;
        assign ch_cont[g]   = cont_q;
        assign ch_irq[g]    = to_q && ito_q;
    end

    // Read mux follows the address every cycle regardless of chipselect.
    always_comb begin
        logic [63:0] per_w;
        logic [63:0] snap_w;
        rd_d   = '0;
        per_w  = 64'(ch_period[ch_sel]);
        snap_w = 64'(ch_snap[ch_sel]);
        irq_d  = |ch_irq;
        if (ch_valid) begin
            case (reg_sel)
                REG_STATUS:   rd_d = {30'b0, ch_run[ch_sel], ch_to[ch_sel]};
                REG_CONTROL:  rd_d = {30'b0, ch_cont[ch_sel], ch_ito[ch_sel]};
                REG_PER_LO:   rd_d = per_w[31:0];
                REG_PER_HI:   rd_d = per_w[63:32];
                REG_SNAP_LO:  rd_d = snap_w[31:0];
                REG_SNAP_HI:  rd_d = snap_w[63:32];
                REG_PRESCALE: rd_d = 32'(ch_pre[ch_sel]);
                default:      rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            irq_q <= irq_d;
        end
    end

    assign bus.readdata = rd_q;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_snake_multi_timer.sv
// Directed bench for snake_multi_timer (NUM_CH=2, CNT_W=48) with a read
// scoreboard; expectations adapt to SNAKE_TIMER_PRESCALE_EN.
module tb_snake_multi_timer;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CNT_W  = 48;

`ifdef SNAKE_TIMER_PRESCALE_EN
    localparam logic [31:0] EXP_PRE = 32'd3;
    localparam int          EXP_INT = 8;
`else
    localparam logic [31:0] EXP_PRE = 32'd0;
    localparam int          EXP_INT = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    snake_multi_timer_if #(.NUM_CH(NUM_CH)) bus ();

    snake_multi_timer #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .RESET_PERIOD (32'd119999),
        .PRE_W        (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [3:0] ad(input int ch, input int r);
        return 4'(ch * 8 + r);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string tag);
        sb.push_back(exp);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(negedge clk);
        bus.chipselect = 1'b0;
        chk(tag, 64'(bus.readdata), 64'(sb.pop_front()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int nedge;
        int last;
        logic prev;

        reset          = 1'b1;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(negedge clk);
        chk("rst_readdata", 64'(bus.readdata), 64'd0);
        chk("rst_irq", 64'(bus.irq), 64'd0);
        reset = 1'b0;

        rd_chk(ad(0, 0), 32'd0,      "rst_status");
        rd_chk(ad(0, 2), 32'd119999, "rst_per_lo");
        rd_chk(ad(0, 3), 32'd0,      "rst_per_hi");
        rd_chk(ad(1, 1), 32'd0,      "rst_ctrl");
        rd_chk(ad(0, 4), 32'd0,      "rst_snap");

        // Continuous count on ch0, counter observed through a snapshot every cycle.
        wr(ad(0, 2), 32'd4);
        wr(ad(0, 3), 32'd0);
        rd_chk(ad(0, 2), 32'd4, "per_lo_rb");
        wr(ad(0, 1), 32'h7);
        m = 4;
        for (int i = 0; i < 14; i++) begin
            bus.address = ad(0, 4);
            if (i < 12) begin
                bus.chipselect = 1'b1;
                bus.write_n    = 1'b0;
                sb.push_back(32'(m));
            end else begin
                bus.chipselect = 1'b0;
                bus.write_n    = 1'b1;
            end
            if (i >= 2) chk("cont_cnt", 64'(bus.readdata), 64'(sb.pop_front()));
            @(negedge clk);
            m = (m == 0) ? 4 : m - 1;
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;

        wr(ad(0, 1), 32'hB);
        rd_chk(ad(0, 1), 32'h3, "ctrl_rb");
        rd_chk(ad(0, 0), 32'h1, "status_to");
        chk("irq_set", 64'(bus.irq), 64'd1);
        wr(ad(0, 0), 32'd0);
        chk("irq_hold", 64'(bus.irq), 64'd1);
        @(negedge clk);
        chk("irq_clear", 64'(bus.irq), 64'd0);

        // STATUS write lands in the first cycle the counter reads 0.
        wr(ad(0, 2), 32'd4);
        wr(ad(0, 1), 32'h7);
        repeat (3) @(negedge clk);
        wr(ad(0, 0), 32'd0);
        rd_chk(ad(0, 0), 32'h3, "collide_to");

        wr(ad(0, 2), 32'd9);
        wr(ad(0, 0), 32'd0);
        wr(ad(0, 1), 32'd0);
        rd_chk(ad(0, 0), 32'd0, "ch0_idle");

        // One-shot on ch1 while ch0 sits still.
        wr(ad(1, 2), 32'd2);
        wr(ad(1, 3), 32'd0);
        wr(ad(1, 1), 32'h4);
        repeat (10) @(negedge clk);
        rd_chk(ad(1, 0), 32'h1, "os_status");
        wr(ad(1, 4), 32'd0);
        rd_chk(ad(1, 4), 32'd0, "os_hold");
        chk("os_noirq", 64'(bus.irq), 64'd0);
        wr(ad(0, 5), 32'd0);
        rd_chk(ad(0, 4), 32'd9, "iso_cnt");
        rd_chk(ad(0, 0), 32'd0, "iso_status");

        // Wide period and snapshot, then a period write mid-run.
        wr(ad(0, 3), 32'd1);
        wr(ad(0, 2), 32'd0);
        wr(ad(0, 1), 32'h6);
        repeat (8) @(negedge clk);
        wr(ad(0, 4), 32'd0);
        rd_chk(ad(0, 4), 32'hFFFF_FFF7, "snap_lo");
        rd_chk(ad(0, 5), 32'd0,         "snap_hi");
        rd_chk(ad(0, 3), 32'd1,         "per_hi_rb");
        wr(ad(0, 2), 32'h20);
        rd_chk(ad(0, 0), 32'd0, "per_stop");
        wr(ad(0, 4), 32'd0);
        rd_chk(ad(0, 4), 32'h20, "per_load_lo");
        rd_chk(ad(0, 5), 32'd1,  "per_load_hi");
        wr(ad(0, 7), 32'hFFFF);
        rd_chk(ad(0, 7), 32'd0, "rsvd");

        // Tick rate: repeated STATUS writes turn each timeout into an irq pulse.
        wr(ad(1, 6), 32'd3);
        rd_chk(ad(1, 6), EXP_PRE, "pre_rb");
        wr(ad(1, 2), 32'd1);
        wr(ad(1, 3), 32'd0);
        wr(ad(1, 1), 32'h7);
        bus.address    = ad(1, 0);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        prev  = bus.irq;
        nedge = 0;
        last  = 0;
        for (int t = 0; t < 80 && nedge < 4; t++) begin
            @(negedge clk);
            if (bus.irq && !prev) begin
                if (nedge > 0) chk("pre_interval", 64'(t - last), 64'(EXP_INT));
                last = t;
                nedge++;
            end
            prev = bus.irq;
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        chk("pre_edges", 64'(nedge), 64'd4);

        // Asynchronous reset while running.
        bus.address = ad(1, 2);
        repeat (20) @(negedge clk);
        chk("pre_reset_irq", 64'(bus.irq), 64'd1);
        chk("pre_reset_rd", 64'(bus.readdata), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rd", 64'(bus.readdata), 64'd0);
        chk("async_irq", 64'(bus.irq), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        wr(ad(1, 4), 32'd0);
        rd_chk(ad(1, 4), 32'd119999, "rst_cnt");
        rd_chk(ad(1, 0), 32'd0,      "rst_status2");
        rd_chk(ad(1, 6), 32'd0,      "rst_pre");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
